lsu_mem_bridge: RTL and testbench

Load/store bridge directly downstream of the datapath's memory port. It consumes Mem_WrAddr, Mem_WrData, the load/store funct3 and the control strobes, and drives a word-wide request/acknowledge data bus with byte enables. It returns the sign- or zero-extended ReadData to the datapath's result mux. It holds the single-cycle core with Stall until the bus access completes, times out, or is rejected as misaligned.

---
 rtl/lsu_mem_bridge.sv | 183 ++++++++++++++++++
 tb/tb_lsu_mem_bridge.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge
// Load/store bridge between the single-cycle core's memory port and a
// word-wide request/acknowledge bus with byte enables.
//
// Ports:
//   clk, reset         core clock (rising edge), async active-high reset
//   MemRead, MemWrite  access strobes from the core (both high = store)
//   funct3             access size/sign (B, H, W, BU, HU; 011/110/111 = W)
//   Mem_WrAddr         byte address
//   Mem_WrData         right-aligned store data
//   ReadData           extended load data to the result mux
//   Stall              hold the core while an access is in flight
//   BusErr             sticky timeout flag, cleared only by reset
//   MisalignErr        one-cycle misalignment pulse (trap build only)
//   bus_req/we/addr/wdata/be   outgoing bus request
//   bus_ack/rdata      bus completion strobe and read word
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/W accesses
// instead of silently aligning them down.

module lsu_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        BusErr,
    output logic        MisalignErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout;
    logic [2:0]       f3_q;     // funct3 of the load in flight
    logic [1:0]       off_q;    // byte lane of the load in flight

    logic             access;
    logic             is_b, is_h;
    logic [1:0]       off;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic             trap;

    assign access = MemRead | MemWrite;
    assign is_b   = (funct3[1:0] == 2'b00);
    assign is_h   = (funct3[1:0] == 2'b01);

    // Lane offset with the sub-size bits dropped: a misaligned H/W access
    // (untrapped) lands on the naturally aligned container.
    always_comb begin
        off   = 2'b00;
        be    = 4'b1111;
        wdata = Mem_WrData;
        if (is_b) begin
            off   = Mem_WrAddr[1:0];
            be    = 4'b0001 << off;
            wdata = {4{Mem_WrData[7:0]}};
        end else if (is_h) begin
            off   = {Mem_WrAddr[1], 1'b0};
            be    = 4'b0011 << off;
            wdata = {2{Mem_WrData[15:0]}};
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = (is_h & Mem_WrAddr[0]) | (funct3[1] & (|Mem_WrAddr[1:0]));
`else
    assign trap = 1'b0;
    assign MisalignErr = 1'b0;
`endif

    assign cnt_inc = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign timeout = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // bus_req follows the state register, so an async reset drops it at once.
    assign bus_req = (state == REQ);

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  lane);
        logic [31:0] sh;
        sh = w >> {lane, 3'b000};
        case (f3[1:0])
            2'b00:   load_ext = f3[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_ext = f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_ext = w;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        Stall     = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    Stall     = 1'b1;
                    state_nxt = trap ? DONE : REQ;
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (bus_ack || timeout)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            bus_be    <= 4'b0000;
            ReadData  <= 32'h0;
            BusErr    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            MisalignErr <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
`ifdef MISALIGN_TRAP_EN
            MisalignErr <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (access) begin
                        if (trap) begin
                            ReadData <= 32'h0;
`ifdef MISALIGN_TRAP_EN
                            MisalignErr <= 1'b1;
`endif
                        end else begin
                            bus_addr  <= {Mem_WrAddr[31:2], 2'b00};
                            bus_we    <= MemWrite;
                            bus_be    <= be;
                            bus_wdata <= wdata;
                            f3_q      <= funct3;
                            off_q     <= off;
                        end
                    end
                end
                REQ: begin
                    // An ack wins over a timeout landing on the same cycle.
                    if (bus_ack) begin
                        if (!bus_we)
                            ReadData <= load_ext(bus_rdata, f3_q, off_q);
                    end else if (timeout) begin
                        BusErr   <= 1'b1;
                        ReadData <= 32'h0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
module tb_lsu_mem_bridge;

    localparam int TMO = 4;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] Mem_WrAddr = 32'h0, Mem_WrData = 32'h0;
    logic [31:0] ReadData;
    logic        Stall, BusErr, MisalignErr;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    lsu_mem_bridge #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData),
        .ReadData(ReadData), .Stall(Stall), .BusErr(BusErr),
        .MisalignErr(MisalignErr), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rd;
        logic        buserr;
        logic        mis;
        int          stall;
    } rsp_exp_t;

    bus_exp_t exp_bus[$];
    rsp_exp_t exp_rsp[$];

    int n_chk = 0;
    int n_err = 0;

    // reference state
    logic [31:0] model_rd = 32'h0;
    logic        model_buserr = 1'b0;

    // bus responder configuration
    bit          rsp_en = 1'b1;
    int          rsp_wait = 0;
    bit          rsp_noack = 1'b0;
    logic [31:0] rsp_rdata = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag_err(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Reference: the access touches sz bytes starting at the aligned-down lane.
    function automatic logic [31:0] ext_model(input logic [31:0] w, input int off,
                                              input int sz, input bit uns);
        longint v;
        v = longint'(w) >> (8 * off);
        if (sz < 4) begin
            v = v & ((64'd1 << (8 * sz)) - 1);
            if (!uns && v >= (64'd1 << (8 * sz - 1)))
                v = v - (64'd1 << (8 * sz));
        end
        return 32'(v);
    endfunction

    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int wt, input bit noack, input logic [31:0] rdata);
        int sz, off, lo;
        bit mis, trap;
        bus_exp_t b;
        rsp_exp_t r;
        bit done;
        sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        lo   = int'(addr % 4);
        mis  = (lo % sz) != 0;
        trap = mis && TRAP;
        off  = (lo / sz) * sz;
        if (!trap) begin
            b.addr = addr - 32'(lo);
            b.we   = wr;
            for (int k = 0; k < 4; k++) begin
                b.be[k] = (k >= off) && (k < off + sz);
                b.wd[8*k +: 8] = data[8*(k % sz) +: 8];
            end
            exp_bus.push_back(b);
        end
        if (trap) begin
            model_rd = 32'h0;
            r.stall  = 1;
        end else if (noack) begin
            model_rd = 32'h0;
            model_buserr = 1'b1;
            r.stall  = 1 + TMO;
        end else begin
            if (!wr) model_rd = ext_model(rdata, off, sz, f3[2]);
            r.stall = wt + 2;
        end
        r.rd = model_rd;
        r.buserr = model_buserr;
        r.mis = trap;
        exp_rsp.push_back(r);

        rsp_wait  = wt;
        rsp_noack = noack;
        rsp_rdata = rdata;
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; funct3 = f3; Mem_WrAddr = addr; Mem_WrData = data;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!Stall) begin done = 1'b1; break; end
        end
        if (!done) flag_err("stall_never_released");
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    // bus responder
    initial begin
        int rcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (rsp_en) begin
                if (bus_req) begin
                    if (!rsp_noack && rcnt == rsp_wait) begin
                        bus_ack = 1'b1; bus_rdata = rsp_rdata;
                    end else begin
                        bus_ack = 1'b0; bus_rdata = $urandom;
                    end
                    rcnt++;
                end else begin
                    bus_ack = 1'b0;
                    rcnt = 0;
                end
            end
        end
    end

    // bus request monitor
    initial begin
        bit req_prev = 1'b0;
        bus_exp_t cur;
        cur = '{32'h0, 1'b0, 4'h0, 32'h0};
        forever begin
            @(negedge clk);
            if (reset) begin
                req_prev = 1'b0;
            end else begin
                if (bus_req && !req_prev) begin
                    if (exp_bus.size() == 0) begin
                        flag_err("bus_req_unexpected");
                    end else begin
                        cur = exp_bus.pop_front();
                        chk("bus_addr", bus_addr, cur.addr);
                        chk("bus_we", 32'(bus_we), 32'(cur.we));
                        chk("bus_be", 32'(bus_be), 32'(cur.be));
                        chk("bus_wdata", bus_wdata, cur.wd);
                    end
                end else if (bus_req) begin
                    chk("bus_addr_stable", bus_addr, cur.addr);
                    chk("bus_wdata_stable", bus_wdata, cur.wd);
                end
                req_prev = bus_req;
            end
        end
    end

    // commit monitor: the core commits on the cycle its access sees Stall low
    initial begin
        int run = 0;
        rsp_exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                run = 0;
            end else if ((MemRead | MemWrite) && !Stall) begin
                if (exp_rsp.size() == 0) begin
                    flag_err("commit_unexpected");
                end else begin
                    e = exp_rsp.pop_front();
                    chk("ReadData", ReadData, e.rd);
                    chk("BusErr", 32'(BusErr), 32'(e.buserr));
                    chk("MisalignErr", 32'(MisalignErr), 32'(e.mis));
                    chk("stall_cycles", 32'(run), 32'(e.stall));
                end
                run = 0;
            end else if (Stall) begin
                run++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3r;
        int sel;
        #12;
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_bus_we", 32'(bus_we), 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_ReadData", ReadData, 32'h0);
        chk("rst_BusErr", 32'(BusErr), 32'h0);
        chk("rst_MisalignErr", 32'(MisalignErr), 32'h0);
        chk("rst_Stall", 32'(Stall), 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // directed cases
        access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
        access(0, 1, 3'b000, 32'h203, 32'h000000A5, 1, 0, 32'h0);
        access(1, 0, 3'b000, 32'h301, 32'h0, 3, 0, 32'h00008000);
        access(1, 0, 3'b100, 32'h301, 32'h0, 3, 0, 32'h00008000);
        access(1, 0, 3'b001, 32'h402, 32'h0, 0, 0, 32'h80010000);
        access(1, 0, 3'b101, 32'h402, 32'h0, 2, 0, 32'h80010000);
        access(1, 1, 3'b001, 32'h0A2, 32'h1234CAFE, 1, 0, 32'hFFFFFFFF);
        access(1, 0, 3'b010, 32'h600, 32'h0, 0, 1, 32'h0);
        access(1, 0, 3'b010, 32'h604, 32'h0, 1, 0, 32'h13579BDF);
        access(1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 32'hA5A55A5A);
        access(0, 1, 3'b001, 32'h107, 32'h0000BEEF, 0, 0, 32'h0);

        // ack while idle is ignored
        rsp_en = 1'b0;
        @(posedge clk); #1 bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1 bus_ack = 1'b0;
        chk("idle_ack_ReadData", ReadData, model_rd);
        chk("idle_ack_bus_req", 32'(bus_req), 32'h0);

        // reset in the middle of a request, ack arriving afterwards
        exp_bus.push_back('{32'h500, 1'b0, 4'hF, 32'h0});
        @(posedge clk); #1;
        MemRead = 1'b1; funct3 = 3'b010; Mem_WrAddr = 32'h500; Mem_WrData = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midreq_bus_req_before", 32'(bus_req), 32'h1);
        reset = 1'b1; MemRead = 1'b0;
        #1;
        chk("midreq_bus_req_async", 32'(bus_req), 32'h0);
        @(posedge clk); #1 reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h12345678;
        @(posedge clk); #1 bus_ack = 1'b0;
        chk("post_rst_bus_req", 32'(bus_req), 32'h0);
        chk("post_rst_ReadData", ReadData, 32'h0);
        chk("post_rst_BusErr", 32'(BusErr), 32'h0);
        chk("post_rst_Stall", 32'(Stall), 32'h0);
        model_rd = 32'h0;
        model_buserr = 1'b0;
        rsp_en = 1'b1;

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 3);
            f3r = 3'($urandom_range(0, 7));
            access(sel != 2 && sel != 3 ? 1'b1 : (sel == 3),
                   sel >= 2, f3r, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 9) == 0, $urandom);
        end

        repeat (5) @(posedge clk);
        chk("bus_queue_drained", 32'(exp_bus.size()), 32'h0);
        chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
